// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score keeper: FSM states, score width, serve directions.
// Pure declarations; no logic, no latency, no flow control.
package pong_pkg;

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    PLAY       = 2'd1,
    POINT      = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam int SCORE_W = 4;

  localparam logic DIR_P1 = 1'b0;
  localparam logic DIR_P2 = 1'b1;

endpackage

// File: rtl/score_keeper_if.sv
// Event inputs and score/serve status outputs of the score keeper, bundled as one port.
// master drives the event pulses, slave (the score keeper) drives the registered status.
interface score_keeper_if;
  import pong_pkg::*;

  logic               frame_tick;
  logic               goal_p1;
  logic               goal_p2;
  logic               serve_req;
  logic               restart;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               serve;
  logic               serve_dir;
  logic               ball_freeze;
  logic               game_over;
  logic               winner;

  modport master (
    output frame_tick, goal_p1, goal_p2, serve_req, restart,
    input  score1, score2, serve, serve_dir, ball_freeze, game_over, winner
  );

  modport slave (
    input  frame_tick, goal_p1, goal_p2, serve_req, restart,
    output score1, score2, serve, serve_dir, ball_freeze, game_over, winner
  );

endinterface

// File: rtl/serve_timer.sv
// Saturating 8-bit frame-tick counter; done is high (from the register) once DELAY ticks are counted.
// One-cycle count latency; clr wins over en; no backpressure.
module serve_timer #(
  parameter int DELAY = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] LIMIT = 8'(DELAY);

  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= 8'd0;
    end else if (en && tick && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign done = (cnt_q == LIMIT);

endmodule

// File: rtl/score_keeper.sv
// Pong score/serve FSM with registered outputs; serve source chosen by PONG_AUTOSERVE_EN (timer) vs serve_req.
// Outputs settle one cycle after the causing pulse; pulses outside their state are dropped, never stalled.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  sk
);

  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               serve_q, serve_d;
  logic               serve_dir_q, serve_dir_d;
  logic               next_dir_q, next_dir_d;
  logic               winner_q, winner_d;
  logic               freeze_q;
  logic               game_over_q;
  logic               serve_cond;

`ifdef PONG_AUTOSERVE_EN
  logic timer_done;
  logic timer_clr;
  logic timer_en;
  logic unused_serve_req;

  // Counting stops on the edge the FSM leaves SERVE_WAIT, so a coincident tick is dropped.
  assign timer_clr        = (state_q != SERVE_WAIT) && (state_d == SERVE_WAIT);
  assign timer_en         = (state_q == SERVE_WAIT) && (state_d == SERVE_WAIT);
  assign serve_cond       = (state_q == SERVE_WAIT) && timer_done;
  assign unused_serve_req = sk.serve_req;

  serve_timer #(
    .DELAY (SERVE_DELAY_FRAMES)
  ) u_serve_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (timer_clr),
    .en    (timer_en),
    .tick  (sk.frame_tick),
    .done  (timer_done)
  );
`else
  logic unused_frame_tick;

  assign serve_cond        = (state_q == SERVE_WAIT) && sk.serve_req;
  assign unused_frame_tick = sk.frame_tick;
`endif

  always_comb begin
    state_d     = state_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_d     = 1'b0;
    serve_dir_d = serve_dir_q;
    next_dir_d  = next_dir_q;
    winner_d    = winner_q;
    case (state_q)
      SERVE_WAIT: begin
        if (serve_cond) begin
          serve_d     = 1'b1;
          serve_dir_d = next_dir_q;
          state_d     = PLAY;
        end
      end
      PLAY: begin
        // A tied pair of goal pulses is ambiguous and dropped entirely.
        if (sk.goal_p1 ^ sk.goal_p2) begin
          if (sk.goal_p1) begin
            if (score1_q < WIN) score1_d = score1_q + 1'b1;
            next_dir_d = DIR_P2;
          end else begin
            if (score2_q < WIN) score2_d = score2_q + 1'b1;
            next_dir_d = DIR_P1;
          end
          state_d = POINT;
        end
      end
      POINT: begin
        if ((score1_q == WIN) || (score2_q == WIN)) begin
          state_d  = GAME_OVER;
          winner_d = (score2_q == WIN);
        end else begin
          state_d = SERVE_WAIT;
        end
      end
      GAME_OVER: begin
        if (sk.restart) begin
          score1_d    = '0;
          score2_d    = '0;
          serve_dir_d = DIR_P2;
          next_dir_d  = DIR_P2;
          state_d     = SERVE_WAIT;
        end
      end
      default: state_d = SERVE_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SERVE_WAIT;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_q     <= 1'b0;
      serve_dir_q <= DIR_P2;
      next_dir_q  <= DIR_P2;
      winner_q    <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_q     <= serve_d;
      serve_dir_q <= serve_dir_d;
      next_dir_q  <= next_dir_d;
      winner_q    <= winner_d;
      freeze_q    <= (state_d != PLAY);
      game_over_q <= (state_d == GAME_OVER);
    end
  end

  assign sk.score1      = score1_q;
  assign sk.score2      = score2_q;
  assign sk.serve       = serve_q;
  assign sk.serve_dir   = serve_dir_q;
  assign sk.ball_freeze = freeze_q;
  assign sk.game_over   = game_over_q;
  assign sk.winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper (WIN_SCORE=3, SERVE_DELAY_FRAMES=2): directed game scenarios then random pulses,
// every cycle compared against a behavioural game model; follows PONG_AUTOSERVE_EN like the design.
module tb_score_keeper;

  localparam int W = 3;
  localparam int D = 2;
`ifdef PONG_AUTOSERVE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  score_keeper_if sk_if ();

  score_keeper #(
    .WIN_SCORE          (W),
    .SERVE_DELAY_FRAMES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sk    (sk_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Game model: what a referee would track, not how the RTL encodes it.
  int m_s1, m_s2, m_ticks;
  bit m_live, m_pend, m_over, m_winner, m_serve, m_dir, m_next_dir;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, t, g1, g2, sq, rs);
    bit fire;
    m_serve = 1'b0;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_ticks = 0;
      m_live = 0; m_pend = 0; m_over = 0; m_winner = 0;
      m_dir = 1; m_next_dir = 1;
    end else if (m_over) begin
      if (rs) begin
        m_s1 = 0; m_s2 = 0; m_ticks = 0; m_over = 0;
        m_dir = 1; m_next_dir = 1;
      end
    end else if (m_pend) begin
      m_pend = 0;
      if (m_s1 == W || m_s2 == W) begin
        m_over   = 1;
        m_winner = (m_s2 == W);
      end else begin
        m_ticks = 0;
      end
    end else if (m_live) begin
      if (g1 != g2) begin
        if (g1) begin
          m_s1 = (m_s1 < W) ? m_s1 + 1 : W;
          m_next_dir = 1;
        end else begin
          m_s2 = (m_s2 < W) ? m_s2 + 1 : W;
          m_next_dir = 0;
        end
        m_live = 0;
        m_pend = 1;
      end
    end else begin
      fire = AUTO ? (m_ticks == D) : sq;
      if (fire) begin
        m_serve = 1;
        m_dir   = m_next_dir;
        m_live  = 1;
      end else if (t && m_ticks < D) begin
        m_ticks++;
      end
    end
  endtask

  task automatic step(input bit r, t, g1, g2, sq, rs);
    reset            = r;
    sk_if.frame_tick = t;
    sk_if.goal_p1    = g1;
    sk_if.goal_p2    = g2;
    sk_if.serve_req  = sq;
    sk_if.restart    = rs;
    @(posedge clk);
    model(r, t, g1, g2, sq, rs);
    @(negedge clk);
    chk("score1", int'(sk_if.score1), m_s1);
    chk("score2", int'(sk_if.score2), m_s2);
    chk("serve", int'(sk_if.serve), int'(m_serve));
    chk("serve_dir", int'(sk_if.serve_dir), int'(m_dir));
    chk("ball_freeze", int'(sk_if.ball_freeze), int'(!m_live));
    chk("game_over", int'(sk_if.game_over), int'(m_over));
    if (m_over) chk("winner", int'(sk_if.winner), int'(m_winner));
  endtask

  // Get the ball moving from SERVE_WAIT; returns cycles spent.
  task automatic launch(output int n);
    n = 0;
`ifdef PONG_AUTOSERVE_EN
    do begin
      step(0, 1, 0, 0, 0, 0);
      n++;
    end while (!sk_if.serve && n < 8);
`else
    step(0, 0, 0, 0, 1, 0);
    n = 1;
`endif
    chk("launch_serve", int'(sk_if.serve), 1);
  endtask

  initial begin
    int n;
    sk_if.frame_tick = 1'b0;
    sk_if.goal_p1    = 1'b0;
    sk_if.goal_p2    = 1'b0;
    sk_if.serve_req  = 1'b0;
    sk_if.restart    = 1'b0;

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 1);
    chk("rst_freeze", int'(sk_if.ball_freeze), 1);
    chk("rst_dir", int'(sk_if.serve_dir), 1);
    chk("rst_over", int'(sk_if.game_over), 0);

    // Reset in the middle of the serve delay discards the partial count.
    step(0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    launch(n);
`ifdef PONG_AUTOSERVE_EN
    chk("full_delay_after_reset", n, D + 1);
`endif
    chk("first_serve_dir", int'(sk_if.serve_dir), 1);
    chk("first_unfreeze", int'(sk_if.ball_freeze), 0);

    // Simultaneous goals are dropped.
    step(0, 0, 1, 1, 0, 0);
    chk("tie_s1", int'(sk_if.score1), 0);
    chk("tie_s2", int'(sk_if.score2), 0);
    chk("tie_still_play", int'(sk_if.ball_freeze), 0);

    // Player 2 scores; next serve heads toward player 1.
    step(0, 0, 0, 1, 0, 0);
    chk("p2_goal_s2", int'(sk_if.score2), 1);
    step(0, 0, 0, 0, 0, 0);
    launch(n);
    chk("serve_to_p1", int'(sk_if.serve_dir), 0);

    // Player 1 wins 3-1; further goals and restart behaviour.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      if (i < 2) launch(n);
    end
    chk("go_over", int'(sk_if.game_over), 1);
    chk("go_winner", int'(sk_if.winner), 0);
    chk("go_s1", int'(sk_if.score1), 3);
    step(0, 1, 1, 0, 1, 0);
    chk("go_hold_s1", int'(sk_if.score1), 3);
    step(0, 0, 0, 0, 0, 1);
    chk("restart_s1", int'(sk_if.score1), 0);
    chk("restart_s2", int'(sk_if.score2), 0);
    chk("restart_freeze", int'(sk_if.ball_freeze), 1);
    chk("restart_over", int'(sk_if.game_over), 0);

`ifndef PONG_AUTOSERVE_EN
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    chk("ticks_no_serve", int'(sk_if.ball_freeze), 1);
    step(0, 0, 0, 0, 1, 0);
    chk("req_serve", int'(sk_if.serve), 1);
    chk("req_play", int'(sk_if.ball_freeze), 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
